// File: rtl/keypad_scan_fifo_pkg.sv
// ============================================================================
// Module  : keypad_scan_fifo_pkg
// Brief   : Shared encodings for the keypad scanner: debounce FSM states and
//           per-frame scan results.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package keypad_scan_fifo_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_cand    = 2'd1;
    localparam logic [1:0] c_st_pressed = 2'd2;

    localparam logic [1:0] c_res_none   = 2'd0;
    localparam logic [1:0] c_res_single = 2'd1;
    localparam logic [1:0] c_res_multi  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/key_fifo.sv
// ============================================================================
// Module  : key_fifo
// Brief   : Show-ahead event FIFO with registered head/valid/full and a sticky
//           overflow flag for pushes dropped while full.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module key_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop_ready,
    input  logic             i_clr_ovf,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;
    logic             r_full;
    logic             r_ovf;

    logic             w_empty;
    logic             w_full_now;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_drop;
    logic [c_aw:0]    w_wr_nxt;
    logic [c_aw:0]    w_rd_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    // Head is precomputed from next-state pointers so every output is a flop.
    always_comb begin
        w_empty    = (r_wr_ptr == r_rd_ptr);
        w_full_now = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                     (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
        w_pop      = i_pop_ready && !w_empty;
        w_wr_en    = i_push && (!w_full_now || w_pop);
        w_drop     = i_push && w_full_now && !w_pop;
        w_wr_nxt   = w_wr_en ? r_wr_ptr + (c_aw+1)'(1) : r_wr_ptr;
        w_rd_nxt   = w_pop   ? r_rd_ptr + (c_aw+1)'(1) : r_rd_ptr;
        if (w_wr_nxt == w_rd_nxt) begin
            w_head_nxt = '0;
        end else if (w_wr_en && (r_wr_ptr[c_aw-1:0] == w_rd_nxt[c_aw-1:0])) begin
            w_head_nxt = i_push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt[c_aw-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_head   <= w_head_nxt;
            r_valid  <= (w_wr_nxt != w_rd_nxt);
            r_full   <= (w_wr_nxt[c_aw-1:0] == w_rd_nxt[c_aw-1:0]) &&
                        (w_wr_nxt[c_aw] != w_rd_nxt[c_aw]);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_head     = r_head;
    assign o_valid    = r_valid;
    assign o_full     = r_full;
    assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: rtl/keypad_scan_fifo.sv
// ============================================================================
// Module  : keypad_scan_fifo
// Brief   : Matrix keypad scanner with per-frame debounce, optional auto-repeat
//           and a show-ahead key event FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module keypad_scan_fifo
    import keypad_scan_fifo_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int KEY_W       = 5,
    parameter int SCAN_DIV    = 5000,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_DLY  = 30,
    parameter int REPEAT_RATE = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  columna,
    output logic [ROWS-1:0]  fila,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_pressed,
    output logic             fifo_full,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int c_row_w  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_div_w  = $clog2(SCAN_DIV);
    localparam int c_db_w   = $clog2(DEBOUNCE + 1);
    localparam int c_rep_w  = $clog2(REPEAT_DLY + 1);
    localparam int c_rate_w = $clog2(REPEAT_RATE + 1);

    logic [c_div_w-1:0]  r_dwell;
    logic [c_row_w-1:0]  r_row;
    logic [ROWS-1:0]     r_fila;
    logic [1:0]          r_hits;
    logic [KEY_W-1:0]    r_code;

    logic [1:0]          r_state;
    logic [KEY_W-1:0]    r_cand;
    logic [c_db_w-1:0]   r_cnt;
    logic [c_db_w-1:0]   r_rel;
    logic [c_rep_w-1:0]  r_rep;
    logic [c_rate_w-1:0] r_rate;
    logic                r_key_pressed;

    logic                w_last_dwell;
    logic                w_last_row;
    logic                w_frame_end;
    logic [c_row_w-1:0]  w_row_nxt;
    logic [1:0]          w_row_hits;
    logic [KEY_W-1:0]    w_row_code;
    logic [1:0]          w_prev_hits;
    logic [1:0]          w_tot_hits;
    logic [KEY_W-1:0]    w_tot_code;
    logic [1:0]          w_frame_res;
    logic                w_same;

    logic [1:0]          w_state_nxt;
    logic [KEY_W-1:0]    w_cand_nxt;
    logic [c_db_w-1:0]   w_cnt_nxt;
    logic [c_db_w-1:0]   w_rel_nxt;
    logic [c_rep_w-1:0]  w_rep_nxt;
    logic [c_rate_w-1:0] w_rate_nxt;
    logic                w_pressed_nxt;
    logic                w_push;
    logic [KEY_W-1:0]    w_push_code;

    // Closure count saturates at 2: anything beyond that is already MULTI.
    always_comb begin
        w_last_dwell = (r_dwell == c_div_w'(SCAN_DIV - 1));
        w_last_row   = (r_row == c_row_w'(ROWS - 1));
        w_frame_end  = w_last_dwell && w_last_row;
        w_row_nxt    = w_last_row ? '0 : r_row + c_row_w'(1);
        w_row_hits   = 2'd0;
        w_row_code   = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!columna[c]) begin
                if (w_row_hits != 2'd2) begin
                    w_row_hits = w_row_hits + 2'd1;
                end
                w_row_code = KEY_W'(int'(r_row) * COLS + c);
            end
        end
        w_prev_hits = (r_row == '0) ? 2'd0 : r_hits;
        if (w_prev_hits == 2'd2 || w_row_hits == 2'd2 ||
            (w_prev_hits == 2'd1 && w_row_hits == 2'd1)) begin
            w_tot_hits = 2'd2;
        end else begin
            w_tot_hits = w_prev_hits | w_row_hits;
        end
        w_tot_code = (w_row_hits == 2'd1) ? w_row_code : r_code;
        case (w_tot_hits)
            2'd0:    w_frame_res = c_res_none;
            2'd1:    w_frame_res = c_res_single;
            default: w_frame_res = c_res_multi;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            r_row   <= '0;
            r_fila  <= ~ROWS'(1);
            r_hits  <= 2'd0;
            r_code  <= '0;
        end else if (w_last_dwell) begin
            r_dwell <= '0;
            r_row   <= w_row_nxt;
            r_fila  <= ~(ROWS'(1) << w_row_nxt);
            r_hits  <= w_tot_hits;
            r_code  <= w_tot_code;
        end else begin
            r_dwell <= r_dwell + c_div_w'(1);
        end
    end

    assign w_same = (w_tot_code == r_cand);

    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_cnt_nxt     = r_cnt;
        w_rel_nxt     = r_rel;
        w_rep_nxt     = r_rep;
        w_rate_nxt    = r_rate;
        w_pressed_nxt = r_key_pressed;
        w_push        = 1'b0;
        w_push_code   = r_cand;
        if (w_frame_end) begin
            case (r_state)
                c_st_idle: begin
                    if (w_frame_res == c_res_single) begin
                        w_cand_nxt = w_tot_code;
                        w_cnt_nxt  = c_db_w'(1);
                        if (DEBOUNCE == 1) begin
                            w_push        = 1'b1;
                            w_push_code   = w_tot_code;
                            w_state_nxt   = c_st_pressed;
                            w_pressed_nxt = 1'b1;
                            w_rel_nxt     = '0;
                            w_rep_nxt     = '0;
                            w_rate_nxt    = '0;
                        end else begin
                            w_state_nxt = c_st_cand;
                        end
                    end
                end
                c_st_cand: begin
                    if (w_frame_res != c_res_single) begin
                        w_state_nxt = c_st_idle;
                    end else if (!w_same) begin
                        w_cand_nxt = w_tot_code;
                        w_cnt_nxt  = c_db_w'(1);
                    end else if (r_cnt == c_db_w'(DEBOUNCE - 1)) begin
                        w_push        = 1'b1;
                        w_state_nxt   = c_st_pressed;
                        w_pressed_nxt = 1'b1;
                        w_rel_nxt     = '0;
                        w_rep_nxt     = '0;
                        w_rate_nxt    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_db_w'(1);
                    end
                end
                c_st_pressed: begin
                    if (w_frame_res == c_res_single && w_same) begin
                        w_rel_nxt = '0;
                        // rep parks at REPEAT_DLY; r_rate paces the later repeats.
                        if (REPEAT_EN != 0) begin
                            if (r_rep != c_rep_w'(REPEAT_DLY)) begin
                                w_rep_nxt = r_rep + c_rep_w'(1);
                                if (r_rep == c_rep_w'(REPEAT_DLY - 1)) begin
                                    w_push     = 1'b1;
                                    w_rate_nxt = '0;
                                end
                            end else if (r_rate == c_rate_w'(REPEAT_RATE - 1)) begin
                                w_push     = 1'b1;
                                w_rate_nxt = '0;
                            end else begin
                                w_rate_nxt = r_rate + c_rate_w'(1);
                            end
                        end
                    end else if (w_frame_res == c_res_multi) begin
                        w_rel_nxt = '0;
                    end else if (r_rel == c_db_w'(DEBOUNCE - 1)) begin
                        w_state_nxt   = c_st_idle;
                        w_pressed_nxt = 1'b0;
                    end else begin
                        w_rel_nxt = r_rel + c_db_w'(1);
                    end
                end
                default: begin
                    w_state_nxt   = c_st_idle;
                    w_pressed_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_cand        <= '0;
            r_cnt         <= '0;
            r_rel         <= '0;
            r_rep         <= '0;
            r_rate        <= '0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cand        <= w_cand_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rel         <= w_rel_nxt;
            r_rep         <= w_rep_nxt;
            r_rate        <= w_rate_nxt;
            r_key_pressed <= w_pressed_nxt;
        end
    end

    key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_code),
        .i_pop_ready (key_ready),
        .i_clr_ovf   (clr_ovf),
        .o_head      (key_code),
        .o_valid     (key_valid),
        .o_full      (fifo_full),
        .o_overflow  (overflow)
    );

    assign fila        = r_fila;
    assign key_pressed = r_key_pressed;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
// ============================================================================
// Module  : tb_keypad_scan_fifo
// Brief   : Scoreboard bench: frame-level keypad model feeds an expected-event
//           queue, a negedge monitor pops and compares DUT outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_scan_fifo;

    localparam int ROWS = 4, COLS = 4, KEY_W = 5, SCAN_DIV = 4, DEBOUNCE = 3;
    localparam int REPEAT_DLY = 4, REPEAT_RATE = 2, FIFO_DEPTH = 4;
    localparam int FRAME = ROWS * SCAN_DIV;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [COLS-1:0]  columna;
    logic [ROWS-1:0]  fila;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready = 1'b0;
    logic             key_pressed;
    logic             fifo_full;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    logic [15:0]      keys = '0;
    int               cyc;
    int               n_vec = 0;
    int               n_err = 0;
    int               ready_mode = 1;
    bit               clr_req = 1'b0;
    bit               pop_now = 1'b0;

    logic [KEY_W-1:0] exp_q[$];
    bit               m_pressed, m_ovf;
    int               m_key, m_run, m_hold, m_quiet;

    keypad_scan_fifo #(
        .ROWS(ROWS), .COLS(COLS), .KEY_W(KEY_W), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE), .REPEAT_EN(1), .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .columna(columna), .fila(fila),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_pressed(key_pressed), .fifo_full(fifo_full), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its column low while its row is driven.
    always_comb begin
        columna = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!fila[r] && keys[r*COLS+c]) columna[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            2:       key_ready = 1'($urandom_range(0, 1));
            default: key_ready = (cyc % FRAME == FRAME - 1);
        endcase
        clr_ovf = clr_req || (ready_mode == 2 && $urandom_range(0, 15) == 0);
    end

    // Frame-level reference: classify the held key set and apply debounce/repeat rules.
    task automatic frame_model(output bit push, output int code);
        int n = $countones(keys);
        int k = -1;
        for (int i = 0; i < 16; i++) if (keys[i]) k = i;
        push = 1'b0;
        code = 0;
        if (!m_pressed) begin
            if (n == 1) begin
                if (k == m_key && m_run > 0) m_run++;
                else begin m_key = k; m_run = 1; end
                if (m_run == DEBOUNCE) begin
                    push = 1'b1; code = m_key;
                    m_pressed = 1'b1; m_hold = 0; m_quiet = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (n == 1 && k == m_key) begin
            m_quiet = 0;
            m_hold++;
            if (m_hold == REPEAT_DLY ||
                (m_hold > REPEAT_DLY && (m_hold - REPEAT_DLY) % REPEAT_RATE == 0)) begin
                push = 1'b1; code = m_key;
            end
        end else if (n >= 2) begin
            m_quiet = 0;
        end else begin
            m_quiet++;
            if (m_quiet == DEBOUNCE) begin m_pressed = 1'b0; m_run = 0; end
        end
    endtask

    always @(negedge clk) begin : model
        bit push, drop;
        int code, occ;
        #1;
        if (!rst_n) begin
            exp_q.delete();
            m_pressed = 1'b0; m_ovf = 1'b0;
            m_key = -1; m_run = 0; m_hold = 0; m_quiet = 0;
        end else begin
            push = 1'b0; code = 0;
            if (cyc % FRAME == FRAME - 1) frame_model(push, code);
            occ  = exp_q.size() + (pop_now ? 1 : 0);
            drop = push && occ == FIFO_DEPTH && !pop_now;
            if (drop)         m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (push && !drop) exp_q.push_back(KEY_W'(code));
        end
    end

    always @(negedge clk) begin : monitor
        logic [3:0] ef;
        if (!rst_n) begin
            pop_now = 1'b0;
        end else begin
            ef = ~(4'b0001 << ((cyc / SCAN_DIV) % ROWS));
            check("fila", 32'(fila), 32'(ef));
            check("key_valid", 32'(key_valid), 32'(exp_q.size() != 0));
            check("key_pressed", 32'(key_pressed), 32'(m_pressed));
            check("fifo_full", 32'(fifo_full), 32'(exp_q.size() == FIFO_DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            pop_now = key_ready && exp_q.size() != 0;
            if (exp_q.size() == 0) begin
                check("key_code_empty", 32'(key_code), 32'(0));
            end else if (key_ready) begin
                check("key_code", 32'(key_code), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic next_frame();
        do begin @(posedge clk); #1; end while (cyc % FRAME != 0);
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        keys = k;
        repeat (n) next_frame();
    endtask

    task automatic check_reset_values();
        check("rst_fila", 32'(fila), 32'(4'b1110));
        check("rst_valid", 32'(key_valid), 32'(0));
        check("rst_code", 32'(key_code), 32'(0));
        check("rst_pressed", 32'(key_pressed), 32'(0));
        check("rst_full", 32'(fifo_full), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : driver
        logic [15:0] pat;
        int kind, a, b;
        int press_keys[5] = '{1, 2, 3, 4, 10};
        #1 rst_n = 1'b0;
        #2 check_reset_values();
        @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;

        ready_mode = 1;
        hold('0, 3);
        hold(16'(1) << 9, 5);
        hold('0, 5);
        repeat (5) begin hold(16'(1) << 6, 1); hold('0, 1); end
        hold('0, 2);
        hold(16'h0021, 6);
        hold(16'h0001, 5);
        hold('0, 4);

        ready_mode = 0;
        foreach (press_keys[i]) begin
            hold(16'(1) << press_keys[i], 4);
            hold('0, 4);
        end
        keys = 16'(1) << 7;
        repeat (2) next_frame();
        ready_mode = 3;
        next_frame();
        ready_mode = 0;
        hold(16'(1) << 7, 1);
        hold('0, 4);
        clr_req = 1'b1;
        hold('0, 1);
        clr_req = 1'b0;
        ready_mode = 1;
        hold('0, 2);

        ready_mode = 2;
        repeat (60) begin
            kind = $urandom_range(0, 3);
            pat  = '0;
            if (kind == 1 || kind == 2) begin
                pat[$urandom_range(0, 15)] = 1'b1;
            end else if (kind == 3) begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                pat[a] = 1'b1;
                pat[b] = 1'b1;
            end
            hold(pat, $urandom_range(1, 6));
        end

        ready_mode = 1;
        hold('0, 4);
        hold(16'(1) << 15, 12);
        hold('0, 4);

        ready_mode = 0;
        keys = 16'(1) << 15;
        repeat (9) next_frame();
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        keys = '0;
        @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
        ready_mode = 1;
        hold('0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
